bram_port_arbiter: RTL and testbench
====================================

// Module: bram_port_arbiter
// PURPOSE
//  Shares one port of the column-write-enabled block RAM among NUM_REQ requesters.
//  Arbitration is round-robin, and each requester uses a valid/ready handshake.
//  Every accepted request returns exactly one response pulse after a fixed latency.
//  A built-in clear sequencer zeroes the whole RAM on command; it sits between the
//  command/config logic and the BRAM port.
// PARAMETERS
//  NUM_REQ     2   number of requesters (>=2)
//  NUM_COL     16  write-enable columns per word
//  COL_WIDTH   32  bits per column
//  ADDR_WIDTH  5   RAM depth = 2**ADDR_WIDTH
// PORTS
//  clock        in   1                       single clock, all logic posedge
//  reset_n      in   1                       synchronous, active-low reset
//  req_valid    in   NUM_REQ                 request valid, one bit per requester
//  req_ready    out  NUM_REQ                 grant (one-hot or zero), combinational
//  req_wen      in   NUM_REQ*NUM_COL         column write enables, requester r at [r*NUM_COL +: NUM_COL]; 0 = read
//  req_addr     in   NUM_REQ*ADDR_WIDTH      word address, packed per requester
//  req_din      in   NUM_REQ*NUM_COL*COL_WIDTH  write data, packed per requester
//  rsp_valid    out  NUM_REQ                 one-cycle response pulse to the owning requester
//  rsp_data     out  NUM_COL*COL_WIDTH       shared response data, = bram_dout
//  clear_start  in   1                       pulse: zero the entire RAM
//  clear_busy   out  1                       clear sequence in progress
//  bram_wen     out  NUM_COL                 to BRAM port, registered
//  bram_addr    out  ADDR_WIDTH              to BRAM port, registered
//  bram_din     out  NUM_COL*COL_WIDTH       to BRAM port, registered
//  bram_dout    in   NUM_COL*COL_WIDTH       from BRAM port (1-cycle registered read)
// BEHAVIOUR
//  Reset (reset_n=0 at a clock edge):
//   - bram_wen, bram_addr, bram_din, rsp_valid, clear_busy and the pipeline tags go to 0.
//   - State goes to IDLE and the RR pointer to NUM_REQ-1, so requester 0 has priority first.
//   - In-flight requests are discarded; no response is issued for them.
//  State machine:
//   - IDLE: arbitrate. clear_start=1 moves to CLEAR, clear counter=0, clear_busy=1 next cycle.
//   - CLEAR: each cycle issue bram_wen=all-ones, bram_din=0, bram_addr=counter, then counter+1.
//     After issuing address 2**ADDR_WIDTH-1, return to IDLE and clear_busy=0 the next cycle.
//   - clear_start while in CLEAR is ignored. Reset mid-clear aborts it; the RAM is left partly cleared.
//  Arbitration (IDLE only, and only when clear_start=0):
//   - Winner is the first req_valid found scanning upward from pointer+1, modulo NUM_REQ.
//   - req_ready[winner]=1 in the same cycle; all other ready bits are 0.
//   - req_ready is all-zero in CLEAR or when clear_start=1. clear_start beats any request.
//   - On handshake the pointer becomes the winner; with no handshake the pointer holds.
//   - req_valid may drop without a handshake. The arbiter does not require valid to be held.
//  Pipeline for a handshake in cycle N:
//   - N+1: bram_wen/addr/din = the winner's fields.
//   - N+2: rsp_valid[winner]=1 and rsp_data = bram_dout.
//   - One request is accepted per cycle, giving a sustained throughput of 1 per clock.
//   - There is no response backpressure; requesters must accept rsp_valid whenever it pulses.
//  Cycles without a handshake drive bram_wen=0 and hold bram_addr/din (read of a don't-care).
//   No rsp_valid is produced for such idle cycles or for clear writes.
//  Writes are read-first: rsp_data for a write returns the word's contents before the write.
//   A read issued the cycle after a write to the same address returns the new data.
//   Partial writes update only the columns whose wen bit is 1.
//  Writes on the other BRAM port are outside this block; no collision checking.
// TESTING
//  1 Reset, then req0 writes addr 3 with wen=all-ones, din=0xA5 pattern, then reads addr 3.
//    -> rsp_valid[0] at N+2 for each request; the read returns the 0xA5 pattern.
//  2 Both requesters hold req_valid for 6 cycles.
//    -> grants alternate 0,1,0,1,0,1; exactly one ready bit per cycle; 6 responses, each to its owner.
//  3 req1 writes addr 7 with wen=0x0001, din column0=0xDEADBEEF over a word previously all 0x11111111.
//    -> a read of addr 7 returns only column0 changed.
//  4 clear_start together with req_valid[0].
//    -> req_ready=0 that cycle; clear_busy high for 2**ADDR_WIDTH cycles; bram_addr steps 0..31;
//       afterwards reads of any address return 0.
//  5 Assert reset_n=0 for one cycle mid-clear, with two reads in flight.
//    -> no rsp_valid for the in-flight reads; clear_busy=0; after reset, requester 0 wins a 0/1 tie.
//  6 Issue clear_start again while clear_busy=1.
//    -> ignored; the sequence still ends after exactly 2**ADDR_WIDTH cycles.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter that shares one column-write-enabled BRAM port among NUM_REQ requesters.
// A built-in sequencer zeroes the whole RAM on command. Responses return two cycles after a handshake.
module bram_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int NUM_COL    = 16,
  parameter int COL_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                                    clock,
  input  logic                                    reset_n,
  input  logic [NUM_REQ-1:0]                      req_valid,
  output logic [NUM_REQ-1:0]                      req_ready,
  input  logic [NUM_REQ*NUM_COL-1:0]              req_wen,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]           req_addr,
  input  logic [NUM_REQ*NUM_COL*COL_WIDTH-1:0]    req_din,
  output logic [NUM_REQ-1:0]                      rsp_valid,
  output logic [NUM_COL*COL_WIDTH-1:0]            rsp_data,
  input  logic                                    clear_start,
  output logic                                    clear_busy,
  output logic [NUM_COL-1:0]                      bram_wen,
  output logic [ADDR_WIDTH-1:0]                   bram_addr,
  output logic [NUM_COL*COL_WIDTH-1:0]            bram_din,
  input  logic [NUM_COL*COL_WIDTH-1:0]            bram_dout
);
  localparam int DW = NUM_COL * COL_WIDTH;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [NUM_COL-1:0]      bram_wen_q, bram_wen_d;
  logic [ADDR_WIDTH-1:0]   bram_addr_q, bram_addr_d;
  logic [DW-1:0]           bram_din_q, bram_din_d;
  // vld_pipe_q[0]: owner of the op on the BRAM port; [1]: owner of the data on bram_dout
  logic [1:0][NUM_REQ-1:0] vld_pipe_q;
  logic [NUM_REQ-1:0]      vld_pipe_d;

  logic [PW-1:0]           cand [NUM_REQ];
  logic [PW-1:0]           win;
  logic                    found;
  logic                    grant;

  // Candidate i is the (i+1)-th requester after the pointer, wrapping around.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cand
    assign cand[i] = PW'((int'(ptr_q) + i + 1) % NUM_REQ);
  end

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[cand[i]]) begin
        found = 1'b1;
        win   = cand[i];
      end
    end
  end

  assign grant     = found && (state_q == IDLE) && !clear_start;
  assign req_ready = grant ? (NUM_REQ'(1) << win) : '0;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    bram_wen_d  = '0;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    vld_pipe_d  = '0;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (grant) begin
          ptr_d       = win;
          bram_wen_d  = req_wen[int'(win)*NUM_COL +: NUM_COL];
          bram_addr_d = req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
          bram_din_d  = req_din[int'(win)*DW +: DW];
          vld_pipe_d  = req_ready;
        end
      end
      CLEAR: begin
        bram_wen_d  = '1;
        bram_addr_d = cnt_q;
        bram_din_d  = '0;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= PW'(NUM_REQ - 1);
      cnt_q       <= '0;
      bram_wen_q  <= '0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      vld_pipe_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      bram_wen_q  <= bram_wen_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      vld_pipe_q  <= {vld_pipe_q[0], vld_pipe_d};
    end
  end

  assign bram_wen   = bram_wen_q;
  assign bram_addr  = bram_addr_q;
  assign bram_din   = bram_din_q;
  assign rsp_valid  = vld_pipe_q[1];
  assign rsp_data   = bram_dout;
  assign clear_busy = (state_q == CLEAR);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a read-first column-write BRAM model on the port.
module tb_bram_port_arbiter;
  logic          clock = 1'b0;
  logic          reset_n;
  logic [1:0]    req_valid, req_ready, rsp_valid;
  logic [31:0]   req_wen;
  logic [9:0]    req_addr;
  logic [1023:0] req_din;
  logic [511:0]  rsp_data, bram_din, bram_dout;
  logic          clear_start, clear_busy;
  logic [15:0]   bram_wen;
  logic [4:0]    bram_addr;

  logic [511:0]  mem [32];
  int            n_cmp = 0;
  int            n_err = 0;

  logic [511:0]  A5, ONES11, WDIN, PART;

  bram_port_arbiter #(.NUM_REQ(2), .NUM_COL(16), .COL_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_addr(req_addr), .req_din(req_din),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .bram_wen(bram_wen), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_dout(bram_dout)
  );

  always #5 clock = ~clock;

  // Read-first BRAM with registered output and per-column write enables
  always @(posedge clock) begin
    bram_dout <= mem[bram_addr];
    for (int c = 0; c < 16; c++)
      if (bram_wen[c]) mem[bram_addr][c*32 +: 32] <= bram_din[c*32 +: 32];
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // One-cycle request from requester r; the grant is checked before the edge.
  task automatic send(input int r, input logic [15:0] wen, input logic [4:0] addr,
                      input logic [511:0] din);
    logic [1:0] e;
    e = '0;
    e[r] = 1'b1;
    req_valid = '0;
    req_valid[r] = 1'b1;
    req_wen[r*16 +: 16] = wen;
    req_addr[r*5 +: 5] = addr;
    req_din[r*512 +: 512] = din;
    #1;
    chk("ready", 512'(req_ready), 512'(e));
    tick();
    req_valid = '0;
  endtask

  task automatic rsp(input string tag, input logic [1:0] v, input logic [511:0] d);
    chk({tag, "_valid"}, 512'(rsp_valid), 512'(v));
    chk({tag, "_data"}, rsp_data, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nb;
    logic [1:0] eg, er;
    A5     = {64{8'hA5}};
    ONES11 = {16{32'h11111111}};
    WDIN   = {{15{32'hCAFEF00D}}, 32'hDEADBEEF};
    PART   = {{15{32'h11111111}}, 32'hDEADBEEF};
    for (int a = 0; a < 32; a++) mem[a] = '0;
    bram_dout = '0;
    reset_n = 1'b0; req_valid = '0; req_wen = '0; req_addr = '0; req_din = '0;
    clear_start = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_wen", 512'(bram_wen), 512'(0));
    chk("rst_addr", 512'(bram_addr), 512'(0));
    chk("rst_din", bram_din, 512'(0));
    chk("rst_rsp", 512'(rsp_valid), 512'(0));
    chk("rst_busy", 512'(clear_busy), 512'(0));
    chk("rst_ready", 512'(req_ready), 512'(0));
    reset_n = 1'b1;

    // 1: full write then read of addr 3
    send(0, 16'hFFFF, 5'd3, A5);
    chk("t1_bwen", 512'(bram_wen), 512'(16'hFFFF));
    chk("t1_baddr", 512'(bram_addr), 512'(3));
    chk("t1_bdin", bram_din, A5);
    send(0, 16'h0000, 5'd3, '0);
    rsp("t1_wr", 2'b01, '0);
    tick();
    rsp("t1_rd", 2'b01, A5);
    tick();
    chk("t1_idle", 512'(rsp_valid), 512'(0));

    // 2: both requesters contend for 6 cycles after a fresh reset
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    req_wen = '0; req_addr = {5'd3, 5'd3};
    for (int i = 0; i < 8; i++) begin
      req_valid = (i < 6) ? 2'b11 : 2'b00;
      #1;
      eg = (i < 6) ? ((i % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      chk("t2_ready", 512'(req_ready), 512'(eg));
      tick();
      er = (i >= 1 && i <= 6) ? (((i - 1) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      chk("t2_rsp", 512'(rsp_valid), 512'(er));
      if (er != 2'b00) chk("t2_data", rsp_data, A5);
    end
    req_valid = '0;

    // 3: partial write of column 0 over an all-0x11111111 word
    send(0, 16'hFFFF, 5'd7, ONES11);
    send(1, 16'h0001, 5'd7, WDIN);
    rsp("t3_fill", 2'b01, '0);
    send(0, 16'h0000, 5'd7, '0);
    rsp("t3_part", 2'b10, ONES11);
    tick();
    rsp("t3_read", 2'b01, PART);

    // 4/6: clear beats a request; a second clear_start mid-sequence is ignored
    req_valid = 2'b01; req_addr = '0; req_wen = '0; clear_start = 1'b1;
    #1;
    chk("t4_ready", 512'(req_ready), 512'(0));
    tick();
    clear_start = 1'b0; req_valid = '0;
    chk("t4_busy", 512'(clear_busy), 512'(1));
    nb = 0;
    while (clear_busy && nb < 100) begin
      nb++;
      if (nb == 5) begin
        req_valid = 2'b01;
        #1;
        chk("t4_ready_clr", 512'(req_ready), 512'(0));
        req_valid = '0;
      end
      if (nb == 10) clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      chk("t4_addr", 512'(bram_addr), 512'(nb - 1));
    end
    chk("t4_len", 512'(nb), 512'(32));
    chk("t4_lastwen", 512'(bram_wen), 512'(16'hFFFF));
    chk("t4_lastdin", bram_din, '0);
    send(0, 16'h0000, 5'd3, '0);
    send(1, 16'h0000, 5'd7, '0);
    rsp("t4_rd3", 2'b01, '0);
    send(0, 16'h0000, 5'd31, '0);
    rsp("t4_rd7", 2'b10, '0);
    tick();
    rsp("t4_rd31", 2'b01, '0);

    // 5: reset mid-clear, then reset with reads in flight
    clear_start = 1'b1; tick(); clear_start = 1'b0;
    repeat (5) tick();
    chk("t5_busy_pre", 512'(clear_busy), 512'(1));
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    chk("t5_busy", 512'(clear_busy), 512'(0));
    chk("t5_wen", 512'(bram_wen), 512'(0));
    chk("t5_addr", 512'(bram_addr), 512'(0));
    send(0, 16'h0000, 5'd3, '0);
    req_valid = 2'b10; reset_n = 1'b0;
    tick();
    req_valid = '0; reset_n = 1'b1;
    chk("t5_drop0", 512'(rsp_valid), 512'(0));
    tick();
    chk("t5_drop1", 512'(rsp_valid), 512'(0));
    req_valid = 2'b11;
    #1;
    chk("t5_tie", 512'(req_ready), 512'(2'b01));
    req_valid = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
